// File: rtl/spi_pkg.sv
// Shared SPI definitions: {CKE,CKP} mode encodings and FSM state type.
// Used by both the master and slave endpoints.
package spi_pkg;

  typedef logic [1:0] spi_mode_t;  // {CKE, CKP}

  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_state_e;

  // Leading edge moves away from the idle level given by ckp.
  function automatic logic lead_edge(input logic ckp, input logic rise, input logic fall);
    return ckp ? fall : rise;
  endfunction

endpackage

// File: rtl/spi_slave_core_if.sv
// Local-side bus of the SPI slave: TX holding handshake, RX strobe, status.
interface spi_slave_core_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall detection.
// Chain resets to RESET_VAL so a line already at that level gives no edge.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{RESET_VAL}};
      last <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      last <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~last;
      fall <= ~sync[SYNC_STAGES-1] & last;
    end
  end

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave endpoint: oversampled Sclk/SS_n/MOSI, all four {CKE,CKP} modes,
// MSB-first shifting with a one-entry TX holding register.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Sclk,
  input  logic SS_n,
  input  logic MOSI,
  input  logic CKP,
  input  logic CKE,
  output logic MISO,
  output logic MISO_oe,
  spi_slave_core_if.slave bus
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES:0] mosi_sync;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(Sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  // SS_n chain resets low so a line held low across reset never looks like a new frame.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ss (
    .clk(clk), .rst_n(rst_n), .d(SS_n), .rise(ss_rise), .fall(ss_fall)
  );

  // One extra stage keeps MOSI aligned with the registered edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-1:0], MOSI};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES];

  spi_state_e            state_q, state_d;
  spi_mode_t             mode_q, mode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic                  ready_q, ready_d, skip_q, skip_d, miso_q, miso_d, oe_q, oe_d;
  logic                  rx_valid_q, rx_valid_d, under_q, under_d, busy_q, busy_d;
  logic                  lead, trail, sample_e, shift_e, load, load_skip;

  assign lead     = lead_edge(mode_q[0], sclk_rise, sclk_fall);
  assign trail    = lead_edge(mode_q[0], sclk_fall, sclk_rise);
  assign sample_e = mode_q[1] ? trail : lead;
  assign shift_e  = mode_q[1] ? lead  : trail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE0;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      hold_q     <= '0;
      rx_data_q  <= '0;
      ready_q    <= 1'b1;
      skip_q     <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      under_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      rx_data_q  <= rx_data_d;
      ready_q    <= ready_d;
      skip_q     <= skip_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      rx_valid_q <= rx_valid_d;
      under_q    <= under_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    rx_data_d  = rx_data_q;
    ready_d    = ready_q;
    skip_d     = skip_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    rx_valid_d = 1'b0;
    under_d    = 1'b0;
    load       = 1'b0;
    load_skip  = 1'b1;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          mode_d    = {CKE, CKP};
          cnt_d     = '0;
          oe_d      = 1'b1;
          load      = 1'b1;
          // With CKE=0 the first shift edge follows the first sample and must shift.
          load_skip = CKE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          cnt_d   = '0;
        end else if (sample_e) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          if (cnt_q == LAST_BIT) begin
            rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            load       = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (shift_e) begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            miso_d     = tx_shift_q[DATA_WIDTH-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load always takes the old holding content; a same-cycle handshake refills it.
    if (load) begin
      tx_shift_d = ready_q ? '0 : hold_q;
      miso_d     = ready_q ? 1'b0 : hold_q[DATA_WIDTH-1];
      skip_d     = load_skip;
      under_d    = ready_q;
      ready_d    = 1'b1;
    end
    if (bus.tx_valid && ready_q) begin
      hold_d  = bus.tx_data;
      ready_d = 1'b0;
    end

    busy_d = (state_d == ACTIVE);
  end

  assign MISO            = miso_q;
  assign MISO_oe         = oe_q;
  assign bus.tx_ready    = ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = under_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a behavioural SPI master drives all modes,
// and received/transmitted words are compared against hand-computed values.
module tb_spi_slave_core;
  import spi_pkg::*;

  localparam int unsigned W = 8;
  localparam int HALF = 8;  // Sclk half period in clk cycles

  logic clk = 1'b0;
  logic rst_n, Sclk, SS_n, MOSI, MISO, MISO_oe, CKP, CKE;

  spi_slave_core_if #(.DATA_WIDTH(W)) bus ();

  spi_slave_core #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .Sclk(Sclk), .SS_n(SS_n), .MOSI(MOSI),
    .CKP(CKP), .CKE(CKE), .MISO(MISO), .MISO_oe(MISO_oe), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int rx_cnt   = 0;
  int und_cnt  = 0;
  logic [W-1:0] rx_last = '0;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_cnt++;
      rx_last = bus.rx_data;
    end
    if (bus.tx_underrun) und_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input spi_mode_t m);
    CKE  = m[1];
    CKP  = m[0];
    Sclk = m[0];
    wait_cyc(2 * HALF);
  endtask

  task automatic frame_start();
    SS_n = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic frame_end();
    wait_cyc(HALF);
    SS_n = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  // Master side of one word: drive MOSI MSB first, capture MISO at the sample edge.
  task automatic xfer(input logic [W-1:0] tx, input int nbits, output logic [W-1:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!CKE) begin
        MOSI = tx[W-1-i];
        wait_cyc(HALF);
        rx   = {rx[W-2:0], MISO};
        Sclk = ~CKP;
        wait_cyc(HALF);
        Sclk = CKP;
      end else begin
        Sclk = ~CKP;
        MOSI = tx[W-1-i];
        wait_cyc(HALF);
        rx   = {rx[W-2:0], MISO};
        Sclk = CKP;
        wait_cyc(HALF);
      end
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    int k = 0;
    while (!bus.tx_ready && k < 100) begin
      wait_cyc(1);
      k++;
    end
    if (!bus.tx_ready) begin
      check("push_timeout", 32'd0, 32'd1);
    end else begin
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      wait_cyc(1);
      bus.tx_valid = 1'b0;
    end
  endtask

  logic [W-1:0] mrx, mrx2;
  int r0, u0;
  spi_mode_t modes[3];
  spi_mode_t b2b[2];

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; Sclk = 1'b0; MOSI = 1'b0; CKP = 1'b0; CKE = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = '0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_oe", 32'(MISO_oe), 32'd0);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_underrun", 32'(bus.tx_underrun), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Mode 0 single word
    set_mode(MODE0);
    push(8'hA5);
    check("m0_ready_drop", 32'(bus.tx_ready), 32'd0);
    r0 = rx_cnt; u0 = und_cnt;
    frame_start();
    check("m0_busy", 32'(bus.busy), 32'd1);
    check("m0_oe", 32'(MISO_oe), 32'd1);
    check("m0_ready_rise", 32'(bus.tx_ready), 32'd1);
    check("m0_no_underrun", 32'(und_cnt - u0), 32'd0);
    xfer(8'h3C, 8, mrx);
    frame_end();
    check("m0_rx_pulses", 32'(rx_cnt - r0), 32'd1);
    check("m0_rx_data", 32'(rx_last), 32'h3C);
    check("m0_master_rx", 32'(mrx), 32'hA5);
    check("m0_oe_off", 32'(MISO_oe), 32'd0);
    check("m0_idle", 32'(bus.busy), 32'd0);

    // Modes 1..3
    modes = '{MODE1, MODE2, MODE3};
    foreach (modes[j]) begin
      set_mode(modes[j]);
      push(8'h81);
      r0 = rx_cnt;
      frame_start();
      xfer(8'h7E, 8, mrx);
      frame_end();
      check($sformatf("mode%0d_rx_pulses", modes[j]), 32'(rx_cnt - r0), 32'd1);
      check($sformatf("mode%0d_rx_data", modes[j]), 32'(rx_last), 32'h7E);
      check($sformatf("mode%0d_master_rx", modes[j]), 32'(mrx), 32'h81);
    end

    // Back-to-back words in one frame, holding refilled after the first load
    b2b = '{MODE0, MODE3};
    foreach (b2b[j]) begin
      set_mode(b2b[j]);
      push(8'h11);
      r0 = rx_cnt;
      frame_start();
      push(8'h22);
      xfer(8'hC3, 8, mrx);
      check($sformatf("b2b%0d_rx1", b2b[j]), 32'(rx_last), 32'hC3);
      check($sformatf("b2b%0d_master1", b2b[j]), 32'(mrx), 32'h11);
      xfer(8'h5A, 8, mrx2);
      frame_end();
      check($sformatf("b2b%0d_rx_pulses", b2b[j]), 32'(rx_cnt - r0), 32'd2);
      check($sformatf("b2b%0d_rx2", b2b[j]), 32'(rx_last), 32'h5A);
      check($sformatf("b2b%0d_master2", b2b[j]), 32'(mrx2), 32'h22);
    end

    // Frame start with empty holding register
    set_mode(MODE0);
    u0 = und_cnt;
    frame_start();
    check("und_pulse", 32'(und_cnt - u0), 32'd1);
    xfer(8'h99, 8, mrx);
    frame_end();
    check("und_master_rx", 32'(mrx), 32'h00);
    check("und_rx_data", 32'(rx_last), 32'h99);

    // Partial word discarded, then a clean frame
    push(8'hF0);
    r0 = rx_cnt;
    frame_start();
    xfer(8'h1F, 5, mrx);
    frame_end();
    check("part_no_rx", 32'(rx_cnt - r0), 32'd0);
    push(8'h0F);
    frame_start();
    xfer(8'hA6, 8, mrx);
    frame_end();
    check("part_next_pulses", 32'(rx_cnt - r0), 32'd1);
    check("part_next_rx", 32'(rx_last), 32'hA6);
    check("part_next_master", 32'(mrx), 32'h0F);

    // Reset mid-word with SS_n held low across release
    push(8'h55);
    frame_start();
    xfer(8'h12, 3, mrx);
    rst_n = 1'b0;
    wait_cyc(2);
    check("mid_rst_miso", 32'(MISO), 32'd0);
    check("mid_rst_oe", 32'(MISO_oe), 32'd0);
    check("mid_rst_ready", 32'(bus.tx_ready), 32'd1);
    check("mid_rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    wait_cyc(10);
    check("post_rst_idle", 32'(bus.busy), 32'd0);
    check("post_rst_oe", 32'(MISO_oe), 32'd0);
    Sclk = CKP;
    SS_n = 1'b1;
    wait_cyc(2 * HALF);
    push(8'h3A);
    r0 = rx_cnt;
    frame_start();
    xfer(8'h6B, 8, mrx);
    frame_end();
    check("post_rst_pulses", 32'(rx_cnt - r0), 32'd1);
    check("post_rst_rx", 32'(rx_last), 32'h6B);
    check("post_rst_master", 32'(mrx), 32'h3A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
